// File: rtl/vinput_pkg.sv
// ============================================================================
// vinput_pkg : shared opcodes, FSM states and idle levels for vinput_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package vinput_pkg;

    typedef enum logic [1:0] {
        OP_TOGGLE = 2'd0,
        OP_SET    = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_PULSE  = 2'd3
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_e;

    localparam logic BTN_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/vinput_pulse_timer.sv
// ============================================================================
// vinput_pulse_timer : load/decrement down-counter, done while count is zero
// Rev 1.0
// ============================================================================
`default_nettype none

module vinput_pulse_timer #(
    parameter int PULSE_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic done_o
);

    localparam int CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at zero, so an idle timer simply keeps reporting done.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/vinput_ctrl.sv
// ============================================================================
// vinput_ctrl : command-driven controller for virtual KEY/SW inputs
// Rev 1.0
// ============================================================================
`default_nettype none

module vinput_ctrl
    import vinput_pkg::*;
#(
    parameter int NUM_BUTTONS  = 4,
    parameter int NUM_SWITCHES = 18,
    parameter int PULSE_CYCLES = 5000000,
    parameter int IDX_W        = $clog2(NUM_BUTTONS + NUM_SWITCHES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [IDX_W-1:0]        cmd_idx,
    output logic [NUM_BUTTONS-1:0]  buttons,
    output logic [NUM_SWITCHES-1:0] switches,
    output logic                    busy,
    output logic                    err
);

    localparam logic [IDX_W-1:0] SW_BASE  = IDX_W'(NUM_BUTTONS);
    localparam logic [IDX_W-1:0] NUM_CHAN = IDX_W'(NUM_BUTTONS + NUM_SWITCHES);

    state_e                  state_q;
    logic [NUM_BUTTONS-1:0]  buttons_q;
    logic [NUM_SWITCHES-1:0] switches_q;
    logic [NUM_BUTTONS-1:0]  pulse_sel_q;
    logic                    err_q;

    op_e                     op;
    logic                    accept;
    logic                    in_range;
    logic                    is_btn;
    logic [IDX_W-1:0]        sw_off;
    logic [NUM_BUTTONS-1:0]  btn_sel;
    logic [NUM_SWITCHES-1:0] sw_sel;
    logic                    pulse_load;
    logic                    pulse_done;

    assign op       = op_e'(cmd_op);
    assign accept   = cmd_valid & cmd_ready;
    assign in_range = (cmd_idx < NUM_CHAN);
    assign is_btn   = (cmd_idx < SW_BASE);
    assign sw_off   = cmd_idx - SW_BASE;

    // One-hot channel selects; shifting avoids out-of-range bit selects.
    always_comb begin
        btn_sel = '0;
        sw_sel  = '0;
        if (in_range && is_btn) begin
            btn_sel = NUM_BUTTONS'(1) << cmd_idx;
        end else if (in_range) begin
            sw_sel = NUM_SWITCHES'(1) << sw_off;
        end
    end

    assign pulse_load = accept && in_range && is_btn && (op == OP_PULSE);

    vinput_pulse_timer #(
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_pulse_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (pulse_load),
        .done_o (pulse_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            buttons_q   <= {NUM_BUTTONS{BTN_IDLE}};
            switches_q  <= {NUM_SWITCHES{SW_IDLE}};
            pulse_sel_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!in_range) begin
                            if (op == OP_CLEAR) begin
                                buttons_q  <= {NUM_BUTTONS{BTN_IDLE}};
                                switches_q <= {NUM_SWITCHES{SW_IDLE}};
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (is_btn) begin
                            case (op)
                                OP_TOGGLE: buttons_q <= buttons_q ^ btn_sel;
                                OP_SET:    buttons_q <= buttons_q & ~btn_sel;
                                OP_CLEAR:  buttons_q <= buttons_q | btn_sel;
                                OP_PULSE: begin
                                    buttons_q   <= buttons_q & ~btn_sel;
                                    pulse_sel_q <= btn_sel;
                                    state_q     <= ST_PULSE;
                                end
                                default: ;
                            endcase
                        end else begin
                            // A PULSE on a switch has no timed meaning; it toggles.
                            case (op)
                                OP_SET:   switches_q <= switches_q | sw_sel;
                                OP_CLEAR: switches_q <= switches_q & ~sw_sel;
                                default:  switches_q <= switches_q ^ sw_sel;
                            endcase
                        end
                    end
                end
                ST_PULSE: begin
                    if (pulse_done) begin
                        buttons_q <= buttons_q | pulse_sel_q;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_PULSE);
    assign buttons   = buttons_q;
    assign switches  = switches_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vinput_ctrl.sv
// ============================================================================
// tb_vinput_ctrl : directed self-checking bench for vinput_ctrl (4 btn, 3 sw)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vinput_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_idx = 3'd0;
    logic [3:0] buttons;
    logic [2:0] switches;
    logic       busy;
    logic       err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vinput_ctrl #(
        .NUM_BUTTONS  (4),
        .NUM_SWITCHES (3),
        .PULSE_CYCLES (4),
        .IDX_W        (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .buttons   (buttons),
        .switches  (switches),
        .busy      (busy),
        .err       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [2:0] idx);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_buttons", 32'(buttons), 32'h0F);
        chk("rst_switches", 32'(switches), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // TOGGLE 1, SET 5, CLEAR 1 back to back
        cmd(2'd0, 3'd1);
        tick();
        chk("toggle1_buttons", 32'(buttons), 32'hD);
        chk("toggle1_switches", 32'(switches), 32'h0);
        cmd(2'd1, 3'd5);
        tick();
        chk("set5_switches", 32'(switches), 32'h2);
        chk("set5_buttons", 32'(buttons), 32'hD);
        cmd(2'd2, 3'd1);
        tick();
        cmd_valid = 1'b0;
        chk("clear1_buttons", 32'(buttons), 32'hF);
        chk("clear1_err", 32'(err), 32'h0);

        // PULSE on button 3 with a TOGGLE 4 waiting behind it
        cmd(2'd3, 3'd3);
        tick();
        cmd_valid = 1'b0;
        chk("pulse_n1_buttons", 32'(buttons), 32'h7);
        chk("pulse_n1_busy", 32'(busy), 32'h1);
        chk("pulse_n1_ready", 32'(cmd_ready), 32'h0);
        tick();
        cmd(2'd0, 3'd4);
        chk("pulse_n2_buttons", 32'(buttons), 32'h7);
        tick();
        chk("pulse_n3_buttons", 32'(buttons), 32'h7);
        chk("pulse_n3_switches", 32'(switches), 32'h2);
        tick();
        chk("pulse_n4_buttons", 32'(buttons), 32'h7);
        chk("pulse_n4_busy", 32'(busy), 32'h1);
        chk("pulse_n4_ready", 32'(cmd_ready), 32'h0);
        tick();
        chk("pulse_n5_buttons", 32'(buttons), 32'hF);
        chk("pulse_n5_busy", 32'(busy), 32'h0);
        chk("pulse_n5_ready", 32'(cmd_ready), 32'h1);
        chk("pulse_n5_switches", 32'(switches), 32'h2);
        tick();
        cmd_valid = 1'b0;
        chk("held_toggle4_switches", 32'(switches), 32'h3);

        // PULSE on switch 6 acts as a toggle
        cmd(2'd3, 3'd6);
        tick();
        cmd_valid = 1'b0;
        chk("swpulse_switches", 32'(switches), 32'h7);
        chk("swpulse_busy", 32'(busy), 32'h0);
        chk("swpulse_ready", 32'(cmd_ready), 32'h1);

        // Out-of-range SET: one-cycle error, no change
        cmd(2'd1, 3'd7);
        tick();
        cmd_valid = 1'b0;
        chk("oor_set_err", 32'(err), 32'h1);
        chk("oor_set_buttons", 32'(buttons), 32'hF);
        chk("oor_set_switches", 32'(switches), 32'h7);
        tick();
        chk("oor_set_err_drop", 32'(err), 32'h0);

        // Press every button, then out-of-range CLEAR resets all
        for (int i = 0; i < 4; i++) begin
            cmd(2'd1, 3'(i));
            tick();
        end
        cmd_valid = 1'b0;
        chk("all_set_buttons", 32'(buttons), 32'h0);
        cmd(2'd2, 3'd7);
        tick();
        cmd_valid = 1'b0;
        chk("oor_clear_buttons", 32'(buttons), 32'hF);
        chk("oor_clear_switches", 32'(switches), 32'h0);
        chk("oor_clear_err", 32'(err), 32'h0);

        // Reset aborts a pulse in progress
        cmd(2'd3, 3'd0);
        tick();
        cmd_valid = 1'b0;
        chk("abort_pressed", 32'(buttons), 32'hE);
        chk("abort_busy_before", 32'(busy), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("abort_buttons", 32'(buttons), 32'hF);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_ready", 32'(cmd_ready), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("after_abort_buttons", 32'(buttons), 32'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
